// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan controller.
//   - 8-bit active-low segment patterns {a,b,c,d,e,f,g,dp} with dp off.
//   - The blank digit code.
//   - Bit positions of each segment on the D_ssd bus.
package ssd_pkg;

  typedef logic [6:0] seg7_t;  // a..g, active-low

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_F     = 8'h71;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam int SEG_A_BIT  = 7;
  localparam int SEG_B_BIT  = 6;
  localparam int SEG_C_BIT  = 5;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 3;
  localparam int SEG_F_BIT  = 2;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

endpackage

// File: rtl/ssd_seg_lut.sv
// ssd_seg_lut: combinational digit code -> a..g segment pattern (active-low).
//   code_i  in  4  digit code; 0..9 digits, 10..14 show 'F', 15 is blank
//   seg_o   out 7  segments a..g, bit6 = a ... bit0 = g
module ssd_seg_lut
  import ssd_pkg::*;
(
  input  logic [3:0] code_i,
  output seg7_t      seg_o
);

  logic [7:0] pat;

  // NOTE: a default ahead of the case keeps every path assigned, so no latch.
  always_comb begin
    pat = SEG_F;
    case (code_i)
      4'd0:       pat = SEG_0;
      4'd1:       pat = SEG_1;
      4'd2:       pat = SEG_2;
      4'd3:       pat = SEG_3;
      4'd4:       pat = SEG_4;
      4'd5:       pat = SEG_5;
      4'd6:       pat = SEG_6;
      4'd7:       pat = SEG_7;
      4'd8:       pat = SEG_8;
      4'd9:       pat = SEG_9;
      CODE_BLANK: pat = SEG_BLANK;
      default:    pat = SEG_F;
    endcase
  end

  assign seg_o = pat[SEG_A_BIT:SEG_G_BIT];

endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: four-digit common-anode seven-segment scan controller.
// Inputs are captured into shadow registers once per frame so the display
// never shows a mix of old and new values.
//   clk       in  1   system clock, rising edge
//   rst       in  1   asynchronous active-high reset
//   bcd       in  16  digit codes, [3:0] = digit 0 (rightmost)
//   dp        in  4   decimal point request per digit, active-high
//   lz_blank  in  1   leading-zero suppression enable
//   ssd_ctl   out 4   digit enables, active-low
//   D_ssd     out 8   segments {a,b,c,d,e,f,g,dp}, active-low
//   frame     out 1   one-cycle pulse on each shadow-register load
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int SCAN_CNT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp,
  input  logic        lz_blank,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  D_ssd,
  output logic        frame
);

  localparam int              CNT_W   = $clog2(SCAN_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_CNT - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      sh_bcd_q, sh_bcd_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             sh_lz_q, sh_lz_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             frame_load;
  logic [3:0]       digit_code;
  seg7_t            lut_seg;
  logic [3:0]       suppress;

  assign tick       = (presc_q == CNT_MAX);
  assign frame_load = tick && (idx_q == 2'd3);
  assign digit_code = sh_bcd_q[{idx_q, 2'b00} +: 4];

  // Suppression chains down from the leftmost digit; digit 0 always shows.
  assign suppress[3] = sh_lz_q && (sh_bcd_q[15:12] == 4'd0);
  assign suppress[2] = suppress[3] && (sh_bcd_q[11:8] == 4'd0);
  assign suppress[1] = suppress[2] && (sh_bcd_q[7:4] == 4'd0);
  assign suppress[0] = 1'b0;

  ssd_seg_lut u_lut (
    .code_i (digit_code),
    .seg_o  (lut_seg)
  );

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    sh_bcd_d = frame_load ? bcd      : sh_bcd_q;
    sh_dp_d  = frame_load ? dp       : sh_dp_q;
    sh_lz_d  = frame_load ? lz_blank : sh_lz_q;
    // Outputs follow the current index, so they lag it by one edge and each
    // digit stays lit for a full prescaler period.
    ctl_d    = ~(4'b0001 << idx_q);
    seg_d    = {(suppress[idx_q] ? 7'h7F : lut_seg), ~sh_dp_q[idx_q]};
    frame_d  = frame_load;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: the shadow registers are reset too, so the display is blank and
  // well-defined before the first frame load rather than showing junk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= CNT_MAX;
      idx_q    <= 2'd3;
      sh_bcd_q <= 16'hFFFF;
      sh_dp_q  <= 4'b0000;
      sh_lz_q  <= 1'b0;
      ctl_q    <= 4'b1111;
      seg_q    <= SEG_BLANK;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sh_bcd_q <= sh_bcd_d;
      sh_dp_q  <= sh_dp_d;
      sh_lz_q  <= sh_lz_d;
      ctl_q    <= ctl_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign ssd_ctl = ctl_q;
  assign D_ssd   = seg_q;
  assign frame   = frame_q;

endmodule

// File: doc/ssd_scan.md
# ssd_scan

Four-digit seven-segment scan controller for the board's common-anode display. It takes four 4-bit digit codes plus per-digit decimal points and time-multiplexes them onto the shared segment bus and the digit-enable lines. Segment patterns come from the team's code-to-pattern mapping. Inputs are captured once per frame into shadow registers, so a value changing mid-scan never tears the display. It sits between the lab datapath (counters, BCD results) and the top-level pins.

## Interface
- SCAN_CNT, 100000: clock cycles each digit is lit (1 kHz digit rate at 100 MHz); legal range ≥ 2; counter width $clog2(SCAN_CNT).
- clk  in  1  system clock; everything on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- bcd  in  16  digit codes; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- dp  in  4  decimal-point request per digit, active-high; bit i = digit i.
- lz_blank  in  1  enables leading-zero suppression.
- ssd_ctl  out  4  digit enables, active-low; at most one bit low.
- D_ssd  out  8  segments, active-low; bit7..bit0 = a,b,c,d,e,f,g,dp.
- frame  out  1  one-cycle pulse marking a shadow-register load.

## Operation
- Prescaler counts 0..SCAN_CNT-1. `tick` = prescaler at SCAN_CNT-1; the prescaler wraps to 0 on tick.
- 2-bit digit index increments on tick and wraps 3→0.
- Frame load: on a tick with index==3, load the shadow registers with bcd, dp and lz_blank, and pulse frame on the same edge.
- Code mapping:
  - 0..9 → digit pattern (0=8'h03, 1=8'h9F, 2=8'h25, 3=8'h0D, 4=8'h99, 5=8'h49, 6=8'h41, 7=8'h1F, 8=8'h01, 9=8'h09).
  - 15 → blank, 8'hFF.
  - 10..14 → 'F', 8'h71.
- Leading-zero suppression, when shadow lz_blank=1:
  - Digit 3 is blanked if its code is 0.
  - Digit k (k = 2, 1) is blanked if its code is 0 and digit k+1 is blanked.
  - Digit 0 is never suppressed.
  - Suppressed digits drive 8'hFF on segments a–g.
- Decimal point: D_ssd[0] = ~shadow_dp[index], independent of blanking or suppression.
- ssd_ctl = ~(4'b0001 << index), registered.

## Timing
- Reset state, applied immediately and without a clock edge:
  - prescaler = SCAN_CNT-1, index = 3.
  - shadow bcd = 16'hFFFF, shadow dp = 0, shadow lz_blank = 0.
  - ssd_ctl = 4'b1111, D_ssd = 8'hFF, frame = 0.
- First edge after rst falls is a wrapping tick: shadow loads, frame=1, index=0.
- ssd_ctl and D_ssd are registered from index and shadow. They show the new digit one edge after index changes, so each digit is lit for exactly SCAN_CNT cycles.
- Frame period is 4×SCAN_CNT cycles. frame is high for exactly one cycle per period.
- Inputs changing between frame pulses have no effect on outputs. Inputs present at the frame edge are captured; no setup beyond normal synchronous timing.
- rst asserted mid-scan: outputs go to reset values asynchronously. The scan restarts per the first-edge rule above.

## Structure
- Shared package `ssd_pkg`:
  - Segment constants (digits 0–9, blank, F) and the blank code 4'hF.
  - Bit-position constants for a–g/dp.
- Sub-module `ssd_seg_lut`: combinational 4-bit code → 7-bit a–g pattern using the package constants. It is instantiated once on the muxed digit code.
- Top: prescaler, index counter, shadow registers, suppression logic, output registers.

## Test plan
- SCAN_CNT=4, bcd=16'h1234, dp=0, rst released:
  - frame=1 at edge 1.
  - Edge 2: ssd_ctl=4'b1110, D_ssd=8'h99.
  - Edge 6: ssd_ctl=4'b1101, D_ssd=8'h0D.
  - Edge 10: ssd_ctl=4'b1011, D_ssd=8'h25.
  - Edge 14: ssd_ctl=4'b0111, D_ssd=8'h9F.
  - frame again at edge 17.
- Mid-frame change, bcd 16'h1234→16'h9999 at edge 5: digits 1–3 still show 3,2,1. Digit 0 shows 8'h09 only from edge 18.
- lz_blank=1:
  - bcd=16'h0050 → digits 3,2 = 8'hFF, digit 1 = 8'h49, digit 0 = 8'h03.
  - bcd=16'h0000 → only digit 0 = 8'h03.
  - bcd=16'h0100 → digit 3 = 8'hFF, digit 2 = 8'h9F, digit 1 = 8'h03, digit 0 = 8'h03.
- Codes and dp, bcd=16'hABCF, dp=4'b1001:
  - Digit 0 = 8'hFE.
  - Digits 1, 2 = 8'h71.
  - Digit 3 = 8'h70.
- Async reset asserted between edges mid-scan: ssd_ctl=4'b1111 and D_ssd=8'hFF before the next clock edge. After release, frame=1 on the first edge.
- Long run with SCAN_CNT=4 over 100 frames, checked continuously:
  - frame period is exactly 16 cycles.
  - ssd_ctl is always one-hot-low, or all-ones only in reset.
